centroid_collector: RTL and testbench

Receiving end of the random centroid generator interface. It accepts candidate centroid coordinates as one-cycle strobes and rejects any candidate that duplicates an entry already stored. It stores up to 8 unique (X,Y) centroids in a table and serves them to the K-means clustering datapath through a registered, indexed read port. Sits between the random centroid source and the distance/assignment stage.

---
 rtl/centroid_collector.sv | 126 ++++++++++++
 tb/tb_centroid_collector.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_collector.sv
// Collects up to 8 unique (X,Y) centroid candidates from the random source and
// serves them through a registered, indexed read port to the K-means datapath.
module centroid_collector (
  input  logic       Random2_clk,
  input  logic       Random2_rst,
  input  logic [3:0] Group_quanI,
  input  logic       Cent_valid,
  input  logic [8:0] Cent_coorX,
  input  logic [8:0] Cent_coorY,
  input  logic       Cent_clear,
  input  logic [2:0] Rd_idx,
  output logic       Cent_ready,
  output logic       Cent_reject,
  output logic       Cent_done,
  output logic [3:0] Cent_count,
  output logic [3:0] Group_quanO,
  output logic [8:0] Rd_coorX,
  output logic [8:0] Rd_coorY
);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

  state_t     state, next_state;
  logic [8:0] tab_x [8];
  logic [8:0] tab_y [8];
  logic [8:0] hold_x, hold_y;
  logic       match;
  logic [3:0] count_inc;
  logic [3:0] target_clamped;
  logic       rd_hit;

  assign count_inc      = Cent_count + 4'd1;
  assign target_clamped = (Group_quanI > 4'd8) ? 4'd8 : Group_quanI;
  assign rd_hit         = ({1'b0, Rd_idx} < Cent_count);

  // Only occupied entries take part in the duplicate search.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < Cent_count) && (tab_x[i] == hold_x) && (tab_y[i] == hold_y))
        match = 1'b1;
    end
  end

  always_ff @(posedge Random2_clk or negedge Random2_rst) begin
    if (!Random2_rst) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Group_quanI != 4'd0) next_state = COLLECT;
      COLLECT: if (Cent_valid) next_state = CHECK;
      CHECK: begin
        if (match)                          next_state = COLLECT;
        else if (count_inc == Group_quanO)  next_state = DONE;
        else                                next_state = COLLECT;
      end
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
    if (Cent_clear) next_state = IDLE;
  end

  always_ff @(posedge Random2_clk or negedge Random2_rst) begin
    if (!Random2_rst) begin
      Cent_ready  <= 1'b0;
      Cent_reject <= 1'b0;
      Cent_done   <= 1'b0;
      Cent_count  <= 4'd0;
      Group_quanO <= 4'd0;
      Rd_coorX    <= 9'd0;
      Rd_coorY    <= 9'd0;
      hold_x      <= 9'd0;
      hold_y      <= 9'd0;
      for (int i = 0; i < 8; i++) begin
        tab_x[i] <= 9'd0;
        tab_y[i] <= 9'd0;
      end
    end else if (Cent_clear) begin
      // Clear wins over any pending write or reject in this cycle.
      Cent_ready  <= 1'b0;
      Cent_reject <= 1'b0;
      Cent_done   <= 1'b0;
      Cent_count  <= 4'd0;
      Group_quanO <= 4'd0;
      Rd_coorX    <= 9'd0;
      Rd_coorY    <= 9'd0;
      hold_x      <= 9'd0;
      hold_y      <= 9'd0;
      for (int i = 0; i < 8; i++) begin
        tab_x[i] <= 9'd0;
        tab_y[i] <= 9'd0;
      end
    end else begin
      Cent_reject <= 1'b0;
      Cent_ready  <= (next_state == COLLECT);
      Cent_done   <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (Group_quanI != 4'd0) Group_quanO <= target_clamped;
        end
        COLLECT: begin
          if (Cent_valid) begin
            hold_x <= Cent_coorX;
            hold_y <= Cent_coorY;
          end
        end
        CHECK: begin
          if (match) begin
            Cent_reject <= 1'b1;
          end else begin
            tab_x[Cent_count[2:0]] <= hold_x;
            tab_y[Cent_count[2:0]] <= hold_y;
            Cent_count             <= count_inc;
          end
        end
        default: ;
      endcase
      Rd_coorX <= rd_hit ? tab_x[Rd_idx] : 9'd0;
      Rd_coorY <= rd_hit ? tab_y[Rd_idx] : 9'd0;
    end
  end

endmodule

// File: tb/tb_centroid_collector.sv
// Scoreboard bench for centroid_collector: stimulus queues expected store/reject
// events and read data; a negedge monitor pops and compares as the DUT reports.
module tb_centroid_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] Group_quanI = 4'd0;
  logic       Cent_valid = 1'b0;
  logic [8:0] Cent_coorX = 9'd0;
  logic [8:0] Cent_coorY = 9'd0;
  logic       Cent_clear = 1'b0;
  logic [2:0] Rd_idx = 3'd0;
  logic       Cent_ready, Cent_reject, Cent_done;
  logic [3:0] Cent_count, Group_quanO;
  logic [8:0] Rd_coorX, Rd_coorY;

  centroid_collector dut (
    .Random2_clk(clk),
    .Random2_rst(rst),
    .Group_quanI(Group_quanI),
    .Cent_valid(Cent_valid),
    .Cent_coorX(Cent_coorX),
    .Cent_coorY(Cent_coorY),
    .Cent_clear(Cent_clear),
    .Rd_idx(Rd_idx),
    .Cent_ready(Cent_ready),
    .Cent_reject(Cent_reject),
    .Cent_done(Cent_done),
    .Cent_count(Cent_count),
    .Group_quanO(Group_quanO),
    .Rd_coorX(Rd_coorX),
    .Rd_coorY(Rd_coorY)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic rej; logic [3:0] cnt; } ev_t;
  typedef struct packed { logic [8:0] x; logic [8:0] y; } rd_t;

  ev_t  ev_q [$];
  rd_t  rd_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_count = 0;
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;
  logic [3:0] prev_count = 4'd0;

  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor: any reject pulse or count change is an event to be matched.
  always @(negedge clk) begin
    ev_t e;
    rd_t r;
    if (Cent_reject || (Cent_count != prev_count)) begin
      n_cmp++;
      if (ev_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got rej=%0b count=%0d, none expected", Cent_reject, Cent_count);
      end else begin
        e = ev_q.pop_front();
        if (e.rej !== Cent_reject || e.cnt !== Cent_count) begin
          n_bad++;
          $display("FAIL event: got rej=%0b count=%0d, expected rej=%0b count=%0d",
                   Cent_reject, Cent_count, e.rej, e.cnt);
        end
      end
    end
    prev_count = Cent_count;
    if (rd_req_d) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL read_underflow: got (%0d,%0d) with no expectation", Rd_coorX, Rd_coorY);
      end else begin
        r = rd_q.pop_front();
        if (Rd_coorX !== r.x || Rd_coorY !== r.y) begin
          n_bad++;
          $display("FAIL read: got (%0d,%0d), expected (%0d,%0d)", Rd_coorX, Rd_coorY, r.x, r.y);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start(input logic [3:0] n);
    Group_quanI = n;
    @(negedge clk);
    Group_quanI = 4'd0;
  endtask

  // kind: 0 ignored, 1 stored, 2 rejected as duplicate
  task automatic strobe(input int x, input int y, input int kind);
    Cent_coorX = 9'(x);
    Cent_coorY = 9'(y);
    Cent_valid = 1'b1;
    if (kind == 1) begin
      model_count++;
      ev_q.push_back('{rej: 1'b0, cnt: 4'(model_count)});
    end else if (kind == 2) begin
      ev_q.push_back('{rej: 1'b1, cnt: 4'(model_count)});
    end
    @(negedge clk);
    Cent_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear();
    if (model_count != 0) ev_q.push_back('{rej: 1'b0, cnt: 4'd0});
    model_count = 0;
    Cent_clear = 1'b1;
    @(negedge clk);
    Cent_clear = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, input int x, input int y);
    Rd_idx = idx;
    rd_req = 1'b1;
    rd_q.push_back('{x: 9'(x), y: 9'(y)});
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_count", Cent_count, 0);
    chk("reset_ready", Cent_ready, 0);
    chk("reset_done", Cent_done, 0);
    chk("reset_quanO", Group_quanO, 0);
    chk("reset_rdx", Rd_coorX, 0);

    // Three entries, target 3
    start(4'd3);
    chk("t3_quanO", Group_quanO, 3);
    chk("t3_ready", Cent_ready, 1);
    strobe(10, 20, 1);
    strobe(30, 40, 1);
    strobe(50, 60, 1);
    chk("t3_done", Cent_done, 1);
    chk("t3_ready_off", Cent_ready, 0);
    rd(3'd0, 10, 20);
    rd(3'd1, 30, 40);
    rd(3'd2, 50, 60);
    rd(3'd3, 0, 0);

    // Duplicate rejection, target 2
    clear();
    chk("clr_done", Cent_done, 0);
    chk("clr_quanO", Group_quanO, 0);
    start(4'd2);
    strobe(5, 5, 1);
    strobe(5, 5, 2);
    strobe(7, 9, 1);
    chk("t2_done", Cent_done, 1);
    rd(3'd0, 5, 5);
    rd(3'd1, 7, 9);
    rd(3'd2, 0, 0);

    // Clamp 12 -> 8, full table, 9th strobe ignored
    clear();
    start(4'd12);
    chk("t8_quanO", Group_quanO, 8);
    for (int i = 0; i < 8; i++) strobe(i * 3 + 1, i * 7 + 2, 1);
    chk("t8_done", Cent_done, 1);
    strobe(100, 100, 0);
    chk("t8_count_hold", Cent_count, 8);
    rd(3'd7, 22, 51);
    rd(3'd4, 13, 30);

    // (0,0) is a legal centroid
    clear();
    start(4'd1);
    strobe(0, 0, 1);
    chk("t1_done", Cent_done, 1);
    rd(3'd0, 0, 0);

    // Clear during CHECK together with a strobe
    clear();
    start(4'd4);
    strobe(1, 2, 1);
    strobe(3, 4, 1);
    Cent_coorX = 9'd9;
    Cent_coorY = 9'd9;
    Cent_valid = 1'b1;
    @(negedge clk);
    ev_q.push_back('{rej: 1'b0, cnt: 4'd0});
    model_count = 0;
    Cent_clear = 1'b1;
    @(negedge clk);
    Cent_clear = 1'b0;
    Cent_valid = 1'b0;
    chk("midclr_done", Cent_done, 0);
    chk("midclr_quanO", Group_quanO, 0);
    chk("midclr_ready", Cent_ready, 0);
    rd(3'd0, 0, 0);
    rd(3'd1, 0, 0);

    // Strobe in IDLE with no request is ignored
    strobe(1, 1, 0);
    chk("idle_count", Cent_count, 0);

    // Strobe held into CHECK: only the COLLECT-cycle sample counts
    start(4'd4);
    Cent_coorX = 9'd11;
    Cent_coorY = 9'd12;
    Cent_valid = 1'b1;
    model_count = 1;
    ev_q.push_back('{rej: 1'b0, cnt: 4'd1});
    @(negedge clk);
    Cent_coorX = 9'd13;
    @(negedge clk);
    Cent_valid = 1'b0;
    @(negedge clk);
    chk("check_strobe_count", Cent_count, 1);
    rd(3'd0, 11, 12);
    rd(3'd1, 0, 0);

    // Asynchronous reset mid-CHECK
    Cent_coorX = 9'd2;
    Cent_coorY = 9'd2;
    Cent_valid = 1'b1;
    @(negedge clk);
    Cent_valid = 1'b0;
    ev_q.push_back('{rej: 1'b0, cnt: 4'd0});
    model_count = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst_count", Cent_count, 0);
    chk("arst_quanO", Group_quanO, 0);
    chk("arst_ready", Cent_ready, 0);
    chk("arst_reject", Cent_reject, 0);
    chk("arst_rdx", Rd_coorX, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_count", Cent_count, 0);
    chk("ev_q_empty", ev_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
